dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 37-bit data memory between the CPU load/store path and a host port (program/data loader, debug reader). Sits between the CPU core and the `data_mem` array, replacing the CPU's direct array access. Provides a request/grant handshake with round-robin fairness, an optional host lock for back-to-back streaming, and a registered read-return path.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/host arbiter for the single-port data memory, with host lock.
// Optional macro DMEM_ARB_BOUNDS_EN: accesses with addr >= DEPTH are suppressed and flagged on err.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 37,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned MA_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU load/store port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // Host loader/debug port
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  // Memory array port
  output logic              m_en,
  output logic              m_we,
  output logic [MA_W-1:0]   m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  typedef enum logic {StIdle, StHlock} state_e;
  typedef enum logic {OwnCpu = 1'b0, OwnHost = 1'b1} owner_e;

  state_e state_q;
  owner_e last_q;
  owner_e rd_owner_q;
  logic   rd_valid_q;

  logic              c_win, h_win;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              oob;
  logic              rd_zero;

  // Arbitration: the lock restricts ownership to the host; otherwise ties go to the
  // requester that was not granted most recently.
  always_comb begin
    c_win = 1'b0;
    h_win = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_req && h_req) begin
          if (last_q == OwnHost) begin
            c_win = 1'b1;
          end else begin
            h_win = 1'b1;
          end
        end else begin
          c_win = c_req;
          h_win = h_req;
        end
      end
      StHlock: begin
        h_win = h_req;
      end
      default: begin
        c_win = 1'b0;
        h_win = 1'b0;
      end
    endcase
  end

  assign c_gnt   = c_win & rst_n;
  assign h_gnt   = h_win & rst_n;
  assign any_gnt = c_gnt | h_gnt;

  assign sel_we    = h_win ? h_we    : c_we;
  assign sel_addr  = h_win ? h_addr  : c_addr;
  assign sel_wdata = h_win ? h_wdata : c_wdata;

`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic err_q;
  logic rd_zero_q;

  assign oob = ({1'b0, sel_addr} >= DepthLim);

  // Out-of-range reads still return a (zero) beat so the requester never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      err_q     <= any_gnt & oob;
      rd_zero_q <= oob;
    end
  end

  assign err     = err_q;
  assign rd_zero = rd_zero_q;
`else
  logic unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign unused_addr_hi = ^sel_addr[ADDR_W-1:MA_W];
  assign oob            = 1'b0;
  assign err            = 1'b0;
  assign rd_zero        = 1'b0;
`endif

  assign m_en    = any_gnt & ~oob;
  assign m_we    = m_en & sel_we;
  assign m_addr  = any_gnt ? sel_addr[MA_W-1:0] : '0;
  assign m_wdata = any_gnt ? sel_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= OwnHost;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OwnCpu;
    end else begin
      if (any_gnt) begin
        last_q <= h_gnt ? OwnHost : OwnCpu;
      end
      rd_valid_q <= any_gnt & ~sel_we;
      rd_owner_q <= h_gnt ? OwnHost : OwnCpu;
      unique case (state_q)
        StIdle: begin
          if (h_gnt && h_lock) begin
            state_q <= StHlock;
          end
        end
        StHlock: begin
          // Leave on an unlocked host grant, or when the host neither requests nor locks.
          if (h_gnt ? !h_lock : (!h_req && !h_lock)) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign c_rvalid = rd_valid_q & (rd_owner_q == OwnCpu);
  assign h_rvalid = rd_valid_q & (rd_owner_q == OwnHost);
  assign c_rdata  = (c_rvalid && !rd_zero) ? m_rdata : '0;
  assign h_rdata  = (h_rvalid && !rd_zero) ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of arbitration and memory.
module tb_dmem_arbiter;
  localparam int unsigned DATA_W = 37;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned MA_W   = $clog2(DEPTH);
`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif
  localparam int WN = 0, WC = 1, WH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              h_req, h_we, h_lock, h_gnt, h_rvalid;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata, h_rdata;
  logic              m_en, m_we, err;
  logic [MA_W-1:0]   m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata = '0;

  int n_checks = 0;
  int n_err    = 0;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Physical memory array behind the arbiter (synchronous read).
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: grant rules, lock flag, word array, and the pending read beat.
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  int                mdl_win = WN;
  bit                mdl_last_host = 1'b1;
  bit                mdl_lock = 1'b0;
  bit                pend_v = 1'b0, pend_err = 1'b0;
  int                pend_owner = WN;
  logic [DATA_W-1:0] pend_data = '0;
  int                win, ea;
  bit                we, drop, exp_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_c_gnt", c_gnt, 0);       chk("rst_h_gnt", h_gnt, 0);
      chk("rst_m_en", m_en, 0);         chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);     chk("rst_m_wdata", m_wdata, 0);
      chk("rst_c_rvalid", c_rvalid, 0); chk("rst_h_rvalid", h_rvalid, 0);
      chk("rst_c_rdata", c_rdata, 0);   chk("rst_h_rdata", h_rdata, 0);
      chk("rst_err", err, 0);
      pend_v = 0; pend_err = 0; mdl_lock = 0; mdl_last_host = 1; mdl_win = WN;
    end else begin
      chk("c_rvalid", c_rvalid, pend_v && pend_owner == WC);
      chk("h_rvalid", h_rvalid, pend_v && pend_owner == WH);
      chk("c_rdata", c_rdata, (pend_v && pend_owner == WC) ? pend_data : '0);
      chk("h_rdata", h_rdata, (pend_v && pend_owner == WH) ? pend_data : '0);
      chk("err", err, pend_err);
      if (mdl_lock)             win = h_req ? WH : WN;
      else if (c_req && h_req)  win = mdl_last_host ? WC : WH;
      else if (c_req)           win = WC;
      else if (h_req)           win = WH;
      else                      win = WN;
      we    = (win == WH) ? h_we    : c_we;
      addr  = (win == WH) ? h_addr  : c_addr;
      wdata = (win == WH) ? h_wdata : c_wdata;
      ea    = int'(addr) % DEPTH;
      drop  = Bounds && (int'(addr) >= DEPTH);
      exp_en = (win != WN) && !drop;
      chk("c_gnt", c_gnt, win == WC);
      chk("h_gnt", h_gnt, win == WH);
      chk("m_en", m_en, exp_en);
      chk("m_we", m_we, exp_en && we);
      if (exp_en) chk("m_addr", m_addr, ea);
      if (exp_en && we) chk("m_wdata", m_wdata, wdata);
      pend_v = 0; pend_err = 0;
      if (win != WN) begin
        mdl_last_host = (win == WH);
        pend_err = drop;
        if (!we) begin
          pend_v = 1; pend_owner = win;
          pend_data = drop ? '0 : ref_mem[ea];
        end else if (!drop) begin
          ref_mem[ea] = wdata;
        end
      end
      if (win == WH)                       mdl_lock = h_lock;
      else if (mdl_lock && !h_req && !h_lock) mdl_lock = 0;
      mdl_win = win;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  localparam logic [DATA_W-1:0] D5 = 37'h1_2345_6789;
  localparam logic [DATA_W-1:0] D8 = 37'h0_DEAD_BEEF;

  logic [63:0] rnd;

  initial begin
    rst_n = 0; c_req = 1; c_we = 0; c_addr = 8'd7; c_wdata = '0;
    h_req = 1; h_we = 0; h_addr = 8'd9; h_wdata = '0; h_lock = 0;
    @(negedge clk);
    chk("reset_gated_c_gnt", c_gnt, 0);
    chk("reset_gated_m_addr", m_addr, 0);
    step();
    rst_n = 1; c_req = 0; h_req = 0;

    // Single CPU store then load
    c_req = 1; c_we = 1; c_addr = 8'd5; c_wdata = D5;
    @(negedge clk);
    chk("st_c_gnt", c_gnt, 1); chk("st_m_we", m_we, 1); chk("st_m_addr", m_addr, 5);
    step();
    c_we = 0; c_wdata = '0;
    @(negedge clk);
    chk("ld_c_gnt", c_gnt, 1);
    step();
    c_req = 0;
    @(negedge clk);
    chk("ld_c_rvalid", c_rvalid, 1); chk("ld_c_rdata", c_rdata, D5);
    chk("ld_h_rvalid", h_rvalid, 0);

    // Contention from reset
    step(); rst_n = 0; @(negedge clk); step(); rst_n = 1;
    c_req = 1; c_we = 0; c_addr = 8'd5; h_req = 1; h_we = 0; h_addr = 8'd5;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin c_req = 0; h_req = 0; end
      @(negedge clk);
      if (i < 6) begin
        chk("tie_c_gnt", c_gnt, (i % 2) == 0);
        chk("tie_h_gnt", h_gnt, (i % 2) == 1);
      end
      if (i > 0) begin
        chk("tie_c_rvalid", c_rvalid, ((i - 1) % 2) == 0);
        chk("tie_h_rvalid", h_rvalid, ((i - 1) % 2) == 1);
        chk("tie_rdata", c_rdata | h_rdata, D5);
      end
      step();
    end

    // Host lock streaming while the CPU waits
    c_req = 1; c_we = 0; c_addr = 8'd5;
    @(negedge clk);
    chk("lk_c_first", c_gnt, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      h_req = 1; h_we = 1; h_addr = ADDR_W'(10 + k); h_wdata = DATA_W'(100 + k);
      h_lock = (k < 4);
      @(negedge clk);
      if (k < 5) begin
        chk("lk_h_gnt", h_gnt, 1); chk("lk_c_wait", c_gnt, 0);
      end else begin
        chk("lk_c_after", c_gnt, 1); chk("lk_h_after", h_gnt, 0);
      end
    end
    step();
    c_req = 0;
    @(negedge clk);
    chk("lk_h_last", h_gnt, 1);
    step();
    h_req = 0; h_lock = 0;

    // Reset during an in-flight CPU read
    c_req = 1; c_we = 0; c_addr = 8'd5;
    @(negedge clk);
    chk("rr_c_gnt", c_gnt, 1);
    step();
    rst_n = 0; h_req = 1; h_we = 0; h_addr = 8'd5;
    @(negedge clk);
    chk("rr_c_rvalid", c_rvalid, 0); chk("rr_c_rdata", c_rdata, 0);
    chk("rr_m_en", m_en, 0);         chk("rr_h_gnt", h_gnt, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rr_cpu_first", c_gnt, 1); chk("rr_host_waits", h_gnt, 0);
    step();
    c_req = 0;
    @(negedge clk);
    chk("rr_host_next", h_gnt, 1);
    step();
    h_req = 0;

    // Out-of-range access
    h_req = 1; h_we = 1; h_addr = 8'd8; h_wdata = D8;
    @(negedge clk);
    chk("oob_prep_h_gnt", h_gnt, 1);
    step();
    h_req = 0; h_we = 0;
    c_req = 1; c_we = 0; c_addr = 8'd40;
    @(negedge clk);
    chk("oob_c_gnt", c_gnt, 1);
    chk("oob_m_en", m_en, !Bounds);
    if (!Bounds) chk("oob_m_addr", m_addr, 8);
    step();
    c_req = 0;
    @(negedge clk);
    chk("oob_c_rvalid", c_rvalid, 1);
    chk("oob_c_rdata", c_rdata, Bounds ? '0 : D8);
    chk("oob_err", err, Bounds);
    step();
    @(negedge clk);
    chk("oob_err_pulse", err, 0);
    step();

    // Randomized traffic: a requester holds its fields until the model says it was granted
    for (int n = 0; n < 3000; n++) begin
      if (!c_req || mdl_win == WC) begin
        c_req = ($urandom_range(0, 3) != 0);
        c_we = 1'($urandom_range(0, 1));
        c_addr = ADDR_W'($urandom_range(0, 39));
        rnd = {$urandom(), $urandom()};
        c_wdata = rnd[DATA_W-1:0];
      end
      if (!h_req || mdl_win == WH) begin
        h_req = ($urandom_range(0, 2) != 0);
        h_we = 1'($urandom_range(0, 1));
        h_addr = ADDR_W'($urandom_range(0, 39));
        rnd = {$urandom(), $urandom()};
        h_wdata = rnd[DATA_W-1:0];
      end
      h_lock = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      step();
    end

    c_req = 0; h_req = 0; h_lock = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
